// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command controller.
package alu_pkg;

    // ALU function codes; 0xF is the ALU default and yields a zero result.
    localparam logic [3:0] AluAdd   = 4'h0;
    localparam logic [3:0] AluSub   = 4'h1;
    localparam logic [3:0] AluMul   = 4'h2;
    localparam logic [3:0] AluDiv   = 4'h3;
    localparam logic [3:0] AluAnd   = 4'h4;
    localparam logic [3:0] AluOr    = 4'h5;
    localparam logic [3:0] AluNand  = 4'h6;
    localparam logic [3:0] AluNor   = 4'h7;
    localparam logic [3:0] AluXor   = 4'h8;
    localparam logic [3:0] AluXnor  = 4'h9;
    localparam logic [3:0] AluCmpEq = 4'hA;
    localparam logic [3:0] AluCmpGt = 4'hB;
    localparam logic [3:0] AluCmpLt = 4'hC;
    localparam logic [3:0] AluSll   = 4'hD;
    localparam logic [3:0] AluSlr   = 4'hE;

    // Frame header bytes.
    localparam logic [7:0] CmdOp  = 8'hCC;
    localparam logic [7:0] CmdNop = 8'hDD;

    typedef enum logic [2:0] {
        StIdle,
        StGetA,
        StGetB,
        StGetFun,
        StAluReq,
        StAluWait,
        StTx
    } ctrl_state_e;

endpackage

// File: rtl/alu_res_ser.sv
// Result serializer: loads a BUSR-wide result and emits it LSB byte first over valid/ready.
module alu_res_ser #(
    parameter int unsigned BUSR = 16
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    input  logic            i_load,
    input  logic [BUSR-1:0] i_data,
    input  logic            i_ready,
    output logic [7:0]      o_data,
    output logic            o_valid,
    output logic            o_done
);

    localparam int unsigned NBytes = BUSR / 8;
    localparam int unsigned CntW   = (NBytes > 1) ? $clog2(NBytes) : 1;
    localparam logic [CntW-1:0] LastByte = CntW'(NBytes - 1);

    logic [BUSR-1:0] shreg_q, shreg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            done;

    // Next-state: load, or shift one byte out on each accepted handshake.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done    = 1'b0;
        if (i_load) begin
            shreg_d = i_data;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && i_ready) begin
            if (cnt_q == LastByte) begin
                valid_d = 1'b0;
                done    = 1'b1;
            end else begin
                shreg_d = shreg_q >> 8;
                cnt_d   = cnt_q + CntW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = shreg_q[7:0];
    assign o_valid = valid_q;
    assign o_done  = done;

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: parses byte frames, issues one ALU op, returns the result bytes.
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned FUN     = 4,
    parameter int unsigned BUSA    = 8,
    parameter int unsigned BUSB    = 8,
    parameter int unsigned BUSR    = BUSA + BUSB,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    input  logic [7:0]      i_rx_data,
    input  logic            i_rx_valid,
    output logic            o_alu_enable,
    output logic [FUN-1:0]  o_alu_fun,
    output logic [BUSA-1:0] o_operan_a,
    output logic [BUSB-1:0] o_operan_b,
    input  logic [BUSR-1:0] i_alu_res,
    input  logic            i_alu_valid,
    output logic [7:0]      o_tx_data,
    output logic            o_tx_valid,
    input  logic            i_tx_ready,
    output logic            o_busy,
    output logic            o_err
);

    localparam int unsigned BytesA = BUSA / 8;
    localparam int unsigned BytesB = BUSB / 8;
    localparam int unsigned MaxIn  = (BytesA > BytesB) ? BytesA : BytesB;
    localparam int unsigned CntW   = (MaxIn > 1) ? $clog2(MaxIn) : 1;
    localparam int unsigned TmoW   = $clog2(TIMEOUT);

    localparam logic [CntW-1:0] LastA   = CntW'(BytesA - 1);
    localparam logic [CntW-1:0] LastB   = CntW'(BytesB - 1);
    localparam logic [TmoW-1:0] LastTmo = TmoW'(TIMEOUT - 1);

    ctrl_state_e     state_q, state_d;
    logic [BUSA-1:0] a_q, a_d;
    logic [BUSB-1:0] b_q, b_d;
    logic [FUN-1:0]  fun_q, fun_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            ser_load;
    logic            ser_done;

    // Next-state, operand assembly, timeout and error detection.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        fun_d    = fun_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        err_d    = 1'b0;
        ser_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CmdOp) begin
                        state_d = StGetA;
                        cnt_d   = '0;
                    end else if (i_rx_data == CmdNop) begin
                        state_d = StGetFun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StGetA: begin
                if (i_rx_valid) begin
                    // Bytes arrive LSB first: shift down, insert at the top.
                    a_d               = a_q >> 8;
                    a_d[BUSA-1 -: 8]  = i_rx_data;
                    if (cnt_q == LastA) begin
                        cnt_d   = '0;
                        state_d = StGetB;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StGetB: begin
                if (i_rx_valid) begin
                    b_d               = b_q >> 8;
                    b_d[BUSB-1 -: 8]  = i_rx_data;
                    if (cnt_q == LastB) begin
                        cnt_d   = '0;
                        state_d = StGetFun;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StGetFun: begin
                if (i_rx_valid) begin
                    if ((i_rx_data >> FUN) != 8'd0) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        fun_d   = i_rx_data[FUN-1:0];
                        state_d = StAluReq;
                    end
                end
            end
            StAluReq: begin
                tmo_d   = '0;
                state_d = StAluWait;
            end
            StAluWait: begin
                if (i_alu_valid) begin
                    ser_load = 1'b1;
                    state_d  = StTx;
                end else if (tmo_q == LastTmo) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StTx: begin
                if (ser_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Bytes arriving while an operation is in flight are dropped and flagged.
        if (i_rx_valid && (state_q inside {StAluReq, StAluWait, StTx})) begin
            err_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    alu_res_ser #(
        .BUSR (BUSR)
    ) u_res_ser (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_load   (ser_load),
        .i_data   (i_alu_res),
        .i_ready  (i_tx_ready),
        .o_data   (o_tx_data),
        .o_valid  (o_tx_valid),
        .o_done   (ser_done)
    );

    assign o_alu_enable = (state_q == StAluReq);
    assign o_alu_fun    = fun_q;
    assign o_operan_a   = a_q;
    assign o_operan_b   = b_q;
    assign o_busy       = (state_q != StIdle);
    assign o_err        = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl with an attached behavioural ALU and frame-level model.
module tb_alu_cmd_ctrl;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        alu_enable;
    logic [3:0]  alu_fun;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic [15:0] alu_res;
    logic        alu_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;
    int exp_err = 0;
    int cyc = 0;
    int en_cyc = 0;
    int err_cyc = 0;

    logic [19:0] exp_en[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  last_a = 8'h00;
    logic [7:0]  last_b = 8'h00;
    logic        alu_kill = 1'b0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        prev_last = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_ctrl #(
        .FUN     (4),
        .BUSA    (8),
        .BUSB    (8),
        .BUSR    (16),
        .TIMEOUT (16)
    ) dut (
        .i_clk        (clk),
        .i_arst_n     (arst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_alu_enable (alu_enable),
        .o_alu_fun    (alu_fun),
        .o_operan_a   (opa),
        .o_operan_b   (opb),
        .i_alu_res    (alu_res),
        .i_alu_valid  (alu_valid),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_busy       (busy),
        .o_err        (err)
    );

    function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [15:0] wa, wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (f)
            4'h0: return wa + wb;
            4'h1: return wa - wb;
            4'h2: return wa * wb;
            4'h3: return (b != 8'h00) ? wa / wb : 16'h0000;
            4'h4: return wa & wb;
            4'h5: return wa | wb;
            4'h6: return {8'h00, ~(a & b)};
            4'h7: return {8'h00, ~(a | b)};
            4'h8: return wa ^ wb;
            4'h9: return {8'h00, ~(a ^ b)};
            4'hA: return (a == b) ? 16'h1 : 16'h0;
            4'hB: return (a > b) ? 16'h1 : 16'h0;
            4'hC: return (a < b) ? 16'h1 : 16'h0;
            4'hD: return wa << 1;
            4'hE: return wa >> 1;
            default: return 16'h0000;
        endcase
    endfunction

    // Attached ALU: registered result, valid one cycle after enable unless suppressed.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            alu_valid <= 1'b0;
            alu_res   <= 16'h0000;
        end else begin
            alu_valid <= alu_enable && !alu_kill;
            if (alu_enable) alu_res <= alu_ref(alu_fun, opa, opb);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the frame-level model.
    always @(negedge clk) begin
        cyc++;
        if (!arst_n) begin
            prev_hold = 1'b0;
            prev_last = 1'b0;
        end else begin
            if (err) begin
                err_seen++;
                err_cyc = cyc;
            end
            if (alu_enable) begin
                en_cyc = cyc;
                if (exp_en.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL enable: got unexpected pulse fun=%0h a=%0h b=%0h, required none",
                             alu_fun, opa, opb);
                end else begin
                    chk("enable_fun_a_b", {12'h0, alu_fun, opa, opb}, {12'h0, exp_en.pop_front()});
                end
            end
            if (prev_last) chk("tx_valid_drop", {31'h0, tx_valid}, 32'h0);
            if (prev_hold) chk("tx_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, prev_data});
            prev_last = 1'b0;
            if (tx_valid && tx_ready) begin
                tx_log.push_back(tx_data);
                if (exp_tx.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_byte: got unexpected byte %0h, required none", tx_data);
                end else begin
                    chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
                    prev_last = (exp_tx.size() == 0);
                end
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    task automatic model_issue(input logic [7:0] f);
        logic [15:0] r;
        if (f[7:4] != 4'h0) begin
            exp_err++;
        end else begin
            exp_en.push_back({f[3:0], last_a, last_b});
            if (alu_kill) begin
                exp_err++;
            end else begin
                r = alu_ref(f[3:0], last_a, last_b);
                exp_tx.push_back(r[7:0]);
                exp_tx.push_back(r[15:8]);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic end_rx();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic frame_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        last_a = a;
        last_b = b;
        model_issue(f);
        send_byte(8'hCC);
        send_byte(a);
        send_byte(b);
        send_byte(f);
        end_rx();
    endtask

    task automatic frame_nop(input logic [7:0] f);
        model_issue(f);
        send_byte(8'hDD);
        send_byte(f);
        end_rx();
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        chk(name, {31'h0, ok}, 32'h1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tx_valid(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (tx_valid) ok = 1'b1;
        end
        chk(name, {31'h0, ok}, 32'h1);
    endtask

    task automatic check_log(input string name, input int n, input logic [7:0] b0,
                             input logic [7:0] b1);
        chk({name, "_count"}, tx_log.size(), n);
        if (n == 2 && tx_log.size() == 2) begin
            chk({name, "_b0"}, {24'h0, tx_log[0]}, {24'h0, b0});
            chk({name, "_b1"}, {24'h0, tx_log[1]}, {24'h0, b1});
        end
        tx_log.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_tx_en_busy_err"}, {28'h0, tx_valid, alu_enable, busy, err}, 32'h0);
        chk({name, "_data"}, {tx_data, alu_fun, 4'h0, opa, opb}, 32'h0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #300000;
        miscompares++;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #3 arst_n = 1'b1;

        // Basic ADD.
        frame_op(8'h05, 8'h03, 8'h00);
        wait_idle("add_idle");
        check_log("add", 2, 8'h08, 8'h00);
        chk("add_busy_low", {31'h0, busy}, 32'h0);

        // MUL then NOP-SUB on stored operands.
        frame_op(8'hFF, 8'hFF, 8'h02);
        wait_idle("mul_idle");
        check_log("mul", 2, 8'h01, 8'hFE);
        frame_nop(8'h01);
        wait_idle("nop_idle");
        check_log("nop_sub", 2, 8'h00, 8'h00);

        // Back-pressure: first byte held while not ready.
        tx_ready = 1'b0;
        frame_op(8'h0A, 8'h03, 8'h0B);
        wait_tx_valid("gt_txv");
        repeat (5) begin
            @(negedge clk);
            chk("gt_hold_data", {24'h0, tx_data}, 32'h01);
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_idle("gt_idle");
        check_log("gt", 2, 8'h01, 8'h00);

        // Bad header byte, then illegal function byte.
        exp_err++;
        send_byte(8'h42);
        end_rx();
        repeat (3) @(negedge clk);
        chk("bad_hdr_err", err_seen, exp_err);
        chk("bad_hdr_busy", {31'h0, busy}, 32'h0);
        frame_op(8'h01, 8'h01, 8'h13);
        wait_idle("bad_fun_idle");
        chk("bad_fun_err", err_seen, exp_err);
        check_log("bad_fun", 0, 8'h00, 8'h00);

        // ALU never answers: timeout error, no TX.
        alu_kill = 1'b1;
        frame_op(8'h01, 8'h02, 8'h00);
        wait_idle("tmo_idle");
        alu_kill = 1'b0;
        chk("tmo_err", err_seen, exp_err);
        chk("tmo_latency_ok", {31'h0, ((err_cyc - en_cyc) >= 16) && ((err_cyc - en_cyc) <= 18)},
            32'h1);
        check_log("tmo", 0, 8'h00, 8'h00);

        // Byte received during TX is dropped with an error; TX unaffected.
        tx_ready = 1'b0;
        frame_op(8'h03, 8'h04, 8'h00);
        wait_tx_valid("rxtx_txv");
        exp_err++;
        send_byte(8'h55);
        end_rx();
        repeat (3) @(negedge clk);
        chk("rxtx_err", err_seen, exp_err);
        chk("rxtx_busy", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_idle("rxtx_idle");
        check_log("rxtx", 2, 8'h07, 8'h00);

        // Reset while collecting operand B.
        send_byte(8'hCC);
        send_byte(8'h07);
        end_rx();
        @(negedge clk);
        chk("getb_busy", {31'h0, busy}, 32'h1);
        #2 arst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        last_a = 8'h00;
        last_b = 8'h00;
        repeat (2) @(posedge clk);
        #3 arst_n = 1'b1;
        frame_op(8'h02, 8'h02, 8'h00);
        wait_idle("post_rst_idle");
        check_log("post_rst", 2, 8'h04, 8'h00);

        chk("final_err", err_seen, exp_err);
        chk("final_en_q", exp_en.size(), 0);
        chk("final_tx_q", exp_tx.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
